// File: rtl/tick_monitor_pkg.sv
// tick_monitor_pkg: FSM state encodings and default divider timing shared by the divider and the monitor.
package tick_monitor_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACQ    = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_LOST   = 2'd3;
  localparam int DEF_EXP_PERIOD = 4;
  localparam int DEF_TOL        = 0;
  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACQ    = ST_ACQ,
    LOCKED = ST_LOCKED,
    LOST   = ST_LOST
  } state_e;
endpackage

// File: rtl/tick_monitor_sync.sv
// tick_sync: multi-flop synchroniser for the divider tick plus a registered rising-edge detector.
module tick_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic _rst,
  input  logic tick_i,
  output logic rise_o
);
  logic [STAGES-1:0] sync_q;
  logic prev_q, rise_q;
  always_ff @(posedge clock or negedge _rst)
    if (!_rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], tick_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
    end
  assign rise_o = rise_q;
endmodule

// File: rtl/tick_monitor.sv
// tick_monitor: measures divider tick spacing, tracks lock and flags short/long periods.
// Define TICK_MON_STATS_EN to build the saturating err_count; otherwise err_count reads 0.
module tick_monitor
  import tick_monitor_pkg::*;
#(
  parameter int CNT_W       = 17,
  parameter int EXP_PERIOD  = DEF_EXP_PERIOD,
  parameter int TOL         = DEF_TOL,
  parameter int LOCK_COUNT  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             _rst,
  input  logic             tick_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err_short,
  output logic             err_long,
  output logic [15:0]      err_count
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] LO  = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0] HI  = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(EXP_PERIOD + TOL + 1);
  localparam logic [MW-1:0] LOCK_N = MW'(LOCK_COUNT);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [MW-1:0] match_q, match_d, match_inc;
  logic rise, good, tmo;
  logic pv_q, pv_d, locked_q, es_q, es_d, el_q, el_d;
  tick_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    ._rst  (_rst),
    .tick_i(tick_in),
    .rise_o(rise)
  );
  always_comb begin
    good      = cnt_q >= LO && cnt_q <= HI;
    tmo       = !rise && cnt_q == TMO;
    match_inc = match_q + MW'(1);
    cnt_d     = rise ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + CNT_W'(1));
    state_d   = state_q;
    match_d   = match_q;
    pv_d      = rise && state_q != IDLE;
    period_d  = pv_d ? cnt_q : period_q;
    es_d      = 1'b0;
    el_d      = 1'b0;
    case (state_q)
      IDLE: if (rise) begin
        state_d = ACQ;
        match_d = '0;
      end
      ACQ: if (rise) begin
        match_d = good ? match_inc : '0;
        if (good && match_inc == LOCK_N) state_d = LOCKED;
      end else if (tmo) state_d = IDLE;
      // a timeout fires once on the way out; LOST never re-flags a long gap
      LOCKED: if ((rise && !good) || tmo) begin
        es_d    = rise && cnt_q < LO;
        el_d    = !es_d;
        state_d = LOST;
      end
      default: if (rise) begin
        state_d = ACQ;
        match_d = '0;
      end
    endcase
  end
  always_ff @(posedge clock or negedge _rst)
    if (!_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      match_q  <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      es_q     <= 1'b0;
      el_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      locked_q <= state_d == LOCKED;
      es_q     <= es_d;
      el_q     <= el_d;
    end
  assign period       = period_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign err_short    = es_q;
  assign err_long     = el_q;
`ifdef TICK_MON_STATS_EN
  logic [15:0] ecnt_q;
  always_ff @(posedge clock or negedge _rst)
    if (!_rst) ecnt_q <= '0;
    else if ((es_d || el_d) && !(&ecnt_q)) ecnt_q <= ecnt_q + 16'd1;
  assign err_count = ecnt_q;
`else
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_tick_monitor.sv
// tb_tick_monitor: directed scenarios for tick_monitor with default parameters.
module tb_tick_monitor;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, lk_prev = 1'b0;
  logic [16:0] period;
  logic period_valid, locked, err_short, err_long;
  logic [15:0] err_count;
  int passed = 0, total = 0;
  int pv_n = 0, es_n = 0, el_n = 0, lr_n = 0, lrp_n = 0, last_period = 0;
  int pv0, es0, el0, lr0, lrp0;
`ifdef TICK_MON_STATS_EN
  localparam int ERRS_T = 1;
  localparam int ERRS_END = 5;
`else
  localparam int ERRS_T = 0;
  localparam int ERRS_END = 0;
`endif
  tick_monitor dut (
    .clock       (clk),
    ._rst        (rst_n),
    .tick_in     (tick),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .err_short   (err_short),
    .err_long    (err_long),
    .err_count   (err_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (period_valid) begin
      pv_n++;
      last_period = int'(period);
    end
    if (err_short) es_n++;
    if (err_long) el_n++;
    if (locked && !lk_prev) begin
      lr_n++;
      if (period_valid) lrp_n++;
    end
    lk_prev = locked;
  end
  task automatic snap();
    pv0 = pv_n; es0 = es_n; el0 = el_n; lr0 = lr_n; lrp0 = lrp_n;
  endtask
  task automatic tick_run(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    tick = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (period !== 17'd0 || period_valid !== 1'b0 || locked !== 1'b0) $display("FAIL reset_outs: period=%0d pv=%b locked=%b want 0/0/0", period, period_valid, locked); else passed++;
    total++; if (err_short !== 1'b0 || err_long !== 1'b0 || err_count !== 16'd0) $display("FAIL reset_errs: es=%b el=%b cnt=%0d want 0/0/0", err_short, err_long, err_count); else passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_lock();
    snap();
    tick_run(3, 4);
    total++; if (pv_n - pv0 !== 2 || last_period !== 4) $display("FAIL lock_first3: pv=%0d period=%0d want 2/4", pv_n - pv0, last_period); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL lock_early: locked=%b want 0", locked); else passed++;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (period_valid !== 1'b0) $display("FAIL lock_latency_early: pv=%b want 0", period_valid); else passed++;
    @(negedge clk);
    total++; if (period_valid !== 1'b1 || locked !== 1'b1 || period !== 17'd4) $display("FAIL lock_latency: pv=%b locked=%b period=%0d want 1/1/4", period_valid, locked, period); else passed++;
    total++; if (lr_n - lr0 !== 1 || lrp_n - lrp0 !== 1) $display("FAIL lock_with_pv: rises=%0d with_pv=%0d want 1/1", lr_n - lr0, lrp_n - lrp0); else passed++;
    total++; if (es_n - es0 !== 0 || el_n - el0 !== 0) $display("FAIL lock_errs: es=%0d el=%0d want 0/0", es_n - es0, el_n - el0); else passed++;
  endtask
  task automatic test_short();
    snap();
    tick_run(1, 3);
    tick_run(1, 4);
    total++; if (es_n - es0 !== 1 || el_n - el0 !== 0) $display("FAIL short_errs: es=%0d el=%0d want 1/0", es_n - es0, el_n - el0); else passed++;
    total++; if (last_period !== 3 || pv_n - pv0 !== 2) $display("FAIL short_period: period=%0d pv=%0d want 3/2", last_period, pv_n - pv0); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL short_unlock: locked=%b want 0", locked); else passed++;
    snap();
    tick_run(3, 4);
    total++; if (locked !== 1'b0) $display("FAIL relock_early: locked=%b want 0", locked); else passed++;
    tick_run(1, 4);
    total++; if (locked !== 1'b1 || lr_n - lr0 !== 1 || pv_n - pv0 !== 4) $display("FAIL relock: locked=%b rises=%0d pv=%0d want 1/1/4", locked, lr_n - lr0, pv_n - pv0); else passed++;
    total++; if (es_n - es0 !== 0 || el_n - el0 !== 0) $display("FAIL relock_errs: es=%0d el=%0d want 0/0", es_n - es0, el_n - el0); else passed++;
  endtask
  task automatic test_async_reset();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    #2;
    total++; if (locked !== 1'b1) $display("FAIL arst_pre: locked=%b want 1", locked); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (period !== 17'd0 || locked !== 1'b0 || period_valid !== 1'b0 || err_count !== 16'd0) $display("FAIL arst_async: period=%0d locked=%b pv=%b cnt=%0d want 0/0/0/0", period, locked, period_valid, err_count); else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    snap();
    tick_run(1, 4);
    total++; if (pv_n - pv0 !== 0) $display("FAIL arst_first_edge: pv=%0d want 0", pv_n - pv0); else passed++;
    tick_run(1, 4);
    total++; if (pv_n - pv0 !== 1 || last_period !== 4) $display("FAIL arst_second_edge: pv=%0d period=%0d want 1/4", pv_n - pv0, last_period); else passed++;
  endtask
  task automatic test_held();
    snap();
    tick = 1'b1;
    repeat (10) @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    tick_run(4, 4);
    total++; if (pv_n - pv0 !== 4 || last_period !== 4) $display("FAIL held_edges: pv=%0d period=%0d want 4/4", pv_n - pv0, last_period); else passed++;
    total++; if (locked !== 1'b1 || es_n - es0 !== 0 || el_n - el0 !== 0) $display("FAIL held_lock: locked=%b es=%0d el=%0d want 1/0/0", locked, es_n - es0, el_n - el0); else passed++;
  endtask
  task automatic test_timeout();
    snap();
    repeat (20) @(negedge clk);
    total++; if (el_n - el0 !== 1 || es_n - es0 !== 0) $display("FAIL timeout_errs: el=%0d es=%0d want 1/0", el_n - el0, es_n - es0); else passed++;
    total++; if (locked !== 1'b0 || period !== 17'd4 || pv_n - pv0 !== 0) $display("FAIL timeout_state: locked=%b period=%0d pv=%0d want 0/4/0", locked, period, pv_n - pv0); else passed++;
    total++; if (err_count !== 16'(ERRS_T)) $display("FAIL timeout_count: err_count=%0d want %0d", err_count, ERRS_T); else passed++;
  endtask
  task automatic test_stats();
    snap();
    tick_run(4, 4);
    total++; if (locked !== 1'b1 || es_n - es0 !== 0) $display("FAIL stats_relock: locked=%b es=%0d want 1/0", locked, es_n - es0); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick_run(1, 3);
      tick_run(5, 4);
    end
    total++; if (locked !== 1'b1 || es_n - es0 !== 3 || el_n - el0 !== 0) $display("FAIL stats_shorts: locked=%b es=%0d el=%0d want 1/3/0", locked, es_n - es0, el_n - el0); else passed++;
    repeat (20) @(negedge clk);
    total++; if (el_n - el0 !== 1 || locked !== 1'b0) $display("FAIL stats_timeout: el=%0d locked=%b want 1/0", el_n - el0, locked); else passed++;
    total++; if (err_count !== 16'(ERRS_END)) $display("FAIL stats_count: err_count=%0d want %0d", err_count, ERRS_END); else passed++;
  endtask
  initial begin
    test_reset();
    test_lock();
    test_short();
    test_async_reset();
    test_held();
    test_timeout();
    test_stats();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
